stream_byte_packer: RTL and testbench

//  Downstream neighbour of the up/down valid-ready handshake register stage.

---
 rtl/stream_byte_packer.sv | 86 ++++++++
 tb/tb_stream_byte_packer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_byte_packer.sv
// stream_byte_packer: packs RATIO narrow beats into one wide word,
// lane 0 first, with early close on up_last and a lane keep mask.
module stream_byte_packer #(
  parameter int WORD_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        up_valid,
  input  logic [WORD_WIDTH-1:0]       up_data,
  input  logic                        up_last,
  output logic                        up_ready,
  output logic                        down_valid,
  output logic [WORD_WIDTH*RATIO-1:0] down_data,
  output logic [RATIO-1:0]            down_keep,
  output logic                        down_last,
  input  logic                        down_ready
);

  localparam int CW = $clog2(RATIO);
  localparam int DW = WORD_WIDTH * RATIO;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_acc;
  logic             r_down_valid;
  logic [DW-1:0]    r_down_data;
  logic [RATIO-1:0] r_down_keep;
  logic             r_down_last;

  logic             w_accept;
  logic             w_close;
  logic             w_drain;
  logic [DW-1:0]    w_word;
  logic [RATIO-1:0] w_keep;

  assign up_ready   = !r_down_valid || down_ready;
  assign w_accept   = up_valid && up_ready;
  assign w_close    = w_accept &&
                      (r_cnt == LAST_LANE || up_last);
  assign w_drain    = r_down_valid && down_ready;

  assign down_valid = r_down_valid;
  assign down_data  = r_down_data;
  assign down_keep  = r_down_keep;
  assign down_last  = r_down_last;

  // merge the incoming beat into lane cnt and build the keep mask
  always_comb begin
    w_word = r_acc;
    w_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CW'(i) == r_cnt)
        w_word[i*WORD_WIDTH +: WORD_WIDTH] = up_data;
      if (CW'(i) <= r_cnt)
        w_keep[i] = 1'b1;
    end
  end

  // accumulator, lane counter and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_down_valid <= 1'b0;
      r_down_data  <= '0;
      r_down_keep  <= '0;
      r_down_last  <= 1'b0;
    end else if (w_close) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_down_valid <= 1'b1;
      r_down_data  <= w_word;
      r_down_keep  <= w_keep;
      r_down_last  <= up_last;
    end else begin
      if (w_accept) begin
        r_acc <= w_word;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_drain)
        r_down_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_byte_packer.sv
// tb_stream_byte_packer: directed and randomized checks of the
// byte packer against a queue-based word grouping model.
module tb_stream_byte_packer;

  localparam int WW = 8;
  localparam int R  = 4;
  localparam int DW = WW * R;

  logic          clk;
  logic          rst_n;
  logic          up_valid;
  logic [WW-1:0] up_data;
  logic          up_last;
  logic          up_ready;
  logic          down_valid;
  logic [DW-1:0] down_data;
  logic [R-1:0]  down_keep;
  logic          down_last;
  logic          down_ready;

  int vecs;
  int errs;

  stream_byte_packer #(
    .WORD_WIDTH(WW),
    .RATIO(R)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .up_valid(up_valid),
    .up_data(up_data),
    .up_last(up_last),
    .up_ready(up_ready),
    .down_valid(down_valid),
    .down_data(down_data),
    .down_keep(down_keep),
    .down_last(down_last),
    .down_ready(down_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [WW-1:0] d,
                      input logic l);
    up_valid = 1'b1;
    up_data  = d;
    up_last  = l;
    tick();
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    up_valid   = 1'b1;
    up_data    = 8'h5A;
    up_last    = 1'b1;
    down_ready = 1'b0;
    tick();
    tick();
    vecs++;
    if (down_valid !== 1'b0 || down_keep !== '0 ||
        down_data !== '0 || down_last !== 1'b0) begin
      errs++;
      $display("FAIL reset_out got v=%b k=%h d=%h l=%b want 0",
               down_valid, down_keep, down_data, down_last);
    end
    rst_n    = 1'b1;
    up_valid = 1'b0;
    up_last  = 1'b0;
    #1;
    vecs++;
    if (up_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready got %b want 1", up_ready);
    end
  endtask

  task automatic test_full_word();
    down_ready = 1'b1;
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    vecs++;
    if (down_valid !== 1'b0) begin
      errs++;
      $display("FAIL full_early got v=%b want 0", down_valid);
    end
    beat(8'h44, 1'b0);
    vecs++;
    if (down_valid !== 1'b1 || down_data !== 32'h44332211 ||
        down_keep !== 4'hF || down_last !== 1'b0) begin
      errs++;
      $display("FAIL full_word got v=%b d=%h k=%h l=%b want 1 44332211 f 0",
               down_valid, down_data, down_keep, down_last);
    end
    tick();
    vecs++;
    if (down_valid !== 1'b0) begin
      errs++;
      $display("FAIL full_drain got v=%b want 0", down_valid);
    end
  endtask

  task automatic test_early_close();
    down_ready = 1'b1;
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b1);
    vecs++;
    if (down_valid !== 1'b1 || down_data !== 32'h0000BBAA ||
        down_keep !== 4'b0011 || down_last !== 1'b1) begin
      errs++;
      $display("FAIL early_word got v=%b d=%h k=%h l=%b want 1 0000bbaa 3 1",
               down_valid, down_data, down_keep, down_last);
    end
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h44, 1'b0);
    vecs++;
    if (down_valid !== 1'b1 || down_data !== 32'h44332211 ||
        down_keep !== 4'hF || down_last !== 1'b0) begin
      errs++;
      $display("FAIL early_restart got v=%b d=%h k=%h l=%b want 1 44332211 f 0",
               down_valid, down_data, down_keep, down_last);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] d;
    down_ready = 1'b0;
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h44, 1'b0);
    up_valid = 1'b1;
    up_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if (up_ready !== 1'b0 || down_valid !== 1'b1 ||
          down_data !== 32'h44332211 || down_keep !== 4'hF ||
          down_last !== 1'b0) begin
        errs++;
        $display("FAIL stall_%0d got r=%b v=%b d=%h k=%h want 0 1 44332211 f",
                 i, up_ready, down_valid, down_data, down_keep);
      end
    end
    down_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = 8'hD0 + 8'(i);
      up_valid = 1'b1;
      up_data  = d;
      up_last  = 1'b1;
      #1;
      vecs++;
      if (up_ready !== 1'b1) begin
        errs++;
        $display("FAIL b2b_ready_%0d got %b want 1", i, up_ready);
      end
      tick();
      vecs++;
      if (down_valid !== 1'b1 || down_data !== {24'h0, d} ||
          down_keep !== 4'b0001 || down_last !== 1'b1) begin
        errs++;
        $display("FAIL b2b_word_%0d got v=%b d=%h k=%h l=%b want 1 %h 1 1",
                 i, down_valid, down_data, down_keep, down_last,
                 {24'h0, d});
      end
    end
    up_valid = 1'b0;
    up_last  = 1'b0;
    tick();
    vecs++;
    if (down_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_drain got v=%b want 0", down_valid);
    end
  endtask

  task automatic test_random_toggle();
    logic [WW-1:0] lanes[$];
    logic [DW-1:0] exp_d[$];
    logic [R-1:0]  exp_k[$];
    logic          exp_l[$];
    logic [DW-1:0] w;
    logic [DW-1:0] hold_d;
    logic [R-1:0]  hold_k;
    logic          hold;
    int            taken;
    int            cyc;
    int            idle;
    taken = 0;
    cyc   = 0;
    idle  = 0;
    hold  = 1'b0;
    hold_d = '0;
    hold_k = '0;
    down_ready = 1'b0;
    while ((taken < 256 || exp_d.size() != 0) && cyc < 4000) begin
      if (taken < 256) begin
        up_valid = ($urandom_range(0, 3) != 0);
        up_data  = 8'($urandom);
        up_last  = (taken == 255) || ($urandom_range(0, 7) == 0);
        down_ready = ~down_ready;
      end else begin
        up_valid = 1'b0;
        up_last  = 1'b0;
        down_ready = 1'b1;
        idle++;
      end
      @(negedge clk);
      if (hold) begin
        vecs++;
        if (down_valid !== 1'b1 || down_data !== hold_d ||
            down_keep !== hold_k) begin
          errs++;
          $display("FAIL rnd_hold got v=%b d=%h k=%h want 1 %h %h",
                   down_valid, down_data, down_keep, hold_d, hold_k);
        end
      end
      vecs++;
      if (up_ready !== (!down_valid || down_ready)) begin
        errs++;
        $display("FAIL rnd_ready got %b want %b",
                 up_ready, (!down_valid || down_ready));
      end
      if (down_valid && down_ready) begin
        vecs++;
        if (exp_d.size() == 0) begin
          errs++;
          $display("FAIL rnd_extra got d=%h want no word", down_data);
        end else begin
          if (down_data !== exp_d[0] || down_keep !== exp_k[0] ||
              down_last !== exp_l[0]) begin
            errs++;
            $display("FAIL rnd_word got d=%h k=%h l=%b want %h %h %b",
                     down_data, down_keep, down_last,
                     exp_d[0], exp_k[0], exp_l[0]);
          end
          void'(exp_d.pop_front());
          void'(exp_k.pop_front());
          void'(exp_l.pop_front());
        end
      end
      if (up_valid && up_ready) begin
        taken++;
        lanes.push_back(up_data);
        if (lanes.size() == R || up_last) begin
          w = '0;
          for (int i = 0; i < lanes.size(); i++)
            w[i*WW +: WW] = lanes[i];
          exp_d.push_back(w);
          exp_k.push_back(R'((1 << lanes.size()) - 1));
          exp_l.push_back(up_last);
          lanes.delete();
        end
      end
      hold   = down_valid && !down_ready;
      hold_d = down_data;
      hold_k = down_keep;
      @(posedge clk);
      #1;
      cyc++;
    end
    up_valid = 1'b0;
    up_last  = 1'b0;
    vecs++;
    if (taken != 256 || exp_d.size() != 0 || lanes.size() != 0) begin
      errs++;
      $display("FAIL rnd_done got beats=%0d words_left=%0d want 256 0",
               taken, exp_d.size());
    end
    tick();
  endtask

  task automatic test_reset_mid_word();
    down_ready = 1'b1;
    beat(8'hE1, 1'b0);
    beat(8'hE2, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b0);
    beat(8'h07, 1'b0);
    vecs++;
    if (down_valid !== 1'b0) begin
      errs++;
      $display("FAIL midrst_early got v=%b d=%h want 0",
               down_valid, down_data);
    end
    beat(8'h08, 1'b0);
    vecs++;
    if (down_valid !== 1'b1 || down_data !== 32'h08070605 ||
        down_keep !== 4'hF || down_last !== 1'b0) begin
      errs++;
      $display("FAIL midrst_word got v=%b d=%h k=%h l=%b want 1 08070605 f 0",
               down_valid, down_data, down_keep, down_last);
    end
    tick();
  endtask

  initial begin
    vecs       = 0;
    errs       = 0;
    rst_n      = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    up_last    = 1'b0;
    down_ready = 1'b0;
    #2;
    test_reset();
    test_full_word();
    test_early_close();
    test_backpressure();
    test_random_toggle();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
